// File: rtl/display_refresh_scheduler.sv
// display_refresh_scheduler: encodes packed BCD to 7-segment frames, shifts them out MSB first, then latches (LZB_EN: leading-zero blanking).
// Latency: upd_ack one cycle after a trigger is seen in IDLE; a frame lasts 2 + DIGITS*SEG_W*2*CLK_DIV + CLK_DIV cycles.
// Backpressure: none; every trigger seen during a frame collapses into a single follow-up frame.
module display_refresh_scheduler #(
  parameter int DIGITS      = 4,
  parameter int SEG_W       = 8,
  parameter int CLK_DIV     = 2,
  parameter int REFRESH_DIV = 1000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [4*DIGITS-1:0] bcd_in,
  input  logic                upd_req,
  output logic                upd_ack,
  output logic                busy,
  output logic                ser_data,
  output logic                ser_clk,
  output logic                ser_latch,
  output logic                frame_done
);
  localparam int NBITS = DIGITS * SEG_W;
  localparam int IW    = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam int DW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int RW    = $clog2(REFRESH_DIV);

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT_LO, SHIFT_HI, LATCH, DONE} state_t;
  state_t state, state_nxt;

  logic [4*DIGITS-1:0] snapshot;
  logic [RW-1:0]       refresh_cnt;
  logic                pending;
  logic [IW-1:0]       idx;
  logic [DW-1:0]       div_cnt;
  logic [NBITS-1:0]    frame;
  logic [3:0]          nib;
  logic                div_last;
  logic                refresh_due;
  logic                trigger;
`ifdef LZB_EN
  logic                lead;
`endif

  function automatic logic [7:0] seg_of(input logic [3:0] n);
    case (n)
      4'd0:    seg_of = 8'h3F;
      4'd1:    seg_of = 8'h06;
      4'd2:    seg_of = 8'h5B;
      4'd3:    seg_of = 8'h4F;
      4'd4:    seg_of = 8'h66;
      4'd5:    seg_of = 8'h6D;
      4'd6:    seg_of = 8'h7D;
      4'd7:    seg_of = 8'h07;
      4'd8:    seg_of = 8'h7F;
      4'd9:    seg_of = 8'h6F;
      default: seg_of = 8'h40;
    endcase
  endfunction

  // Frame is encoded from the snapshot so it stays stable for the whole shift.
  always_comb begin
    frame = '0;
    nib   = '0;
`ifdef LZB_EN
    lead  = 1'b1;
`endif
    for (int d = DIGITS - 1; d >= 0; d--) begin
      nib = snapshot[4*d +: 4];
`ifdef LZB_EN
      if (lead && nib == 4'd0 && d != 0) begin
        frame[d*SEG_W +: SEG_W] = '0;
      end else begin
        lead = 1'b0;
        frame[d*SEG_W +: SEG_W] = SEG_W'(seg_of(nib));
      end
`else
      frame[d*SEG_W +: SEG_W] = SEG_W'(seg_of(nib));
`endif
    end
  end

  assign div_last    = (div_cnt == DW'(CLK_DIV - 1));
  assign refresh_due = (refresh_cnt == RW'(REFRESH_DIV - 1));
  assign trigger     = upd_req | pending | (bcd_in != snapshot) | refresh_due;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    upd_ack    = 1'b0;
    busy       = 1'b1;
    ser_data   = 1'b0;
    ser_clk    = 1'b0;
    ser_latch  = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (trigger) state_nxt = LOAD;
      end
      LOAD: begin
        upd_ack   = 1'b1;
        state_nxt = SHIFT_LO;
      end
      SHIFT_LO: begin
        ser_data = frame[idx];
        if (div_last) state_nxt = SHIFT_HI;
      end
      SHIFT_HI: begin
        ser_data = frame[idx];
        ser_clk  = 1'b1;
        if (div_last) state_nxt = (idx == '0) ? LATCH : SHIFT_LO;
      end
      LATCH: begin
        ser_latch = 1'b1;
        if (div_last) state_nxt = DONE;
      end
      DONE: begin
        frame_done = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      snapshot    <= '0;
      refresh_cnt <= '0;
      pending     <= 1'b1;
      idx         <= '0;
      div_cnt     <= '0;
    end else begin
      div_cnt <= (state_nxt != state) ? '0 : div_cnt + DW'(1);
      case (state)
        IDLE: if (!trigger) refresh_cnt <= refresh_cnt + RW'(1);
        LOAD: begin
          snapshot    <= bcd_in;
          pending     <= 1'b0;
          refresh_cnt <= '0;
          idx         <= IW'(NBITS - 1);
        end
        SHIFT_HI: if (div_last && idx != '0) idx <= idx - IW'(1);
        default: ;
      endcase
      // LOAD itself absorbs anything seen in its own cycle.
      if (state != IDLE && state != LOAD && (upd_req || bcd_in != snapshot))
        pending <= 1'b1;
    end
  end

endmodule
